exa_crosb_vc_out_arbiter: RTL and testbench

EXA_CROSB_VC_OUT_ARBITER -- requirements
Module: exa_crosb_vc_out_arbiter

---
 rtl/exa_crosb_vc_out_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_exa_crosb_vc_out_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exa_crosb_vc_out_arbiter.sv
// ---------------------------------------------------------------------------
// exa_crosb_vc_out_arbiter
//
// Per-output arbiter for the crossbar. Picks one of NUM_IN competing inputs
// and holds that grant for a whole packet. Within each priority class it uses
// a separate round-robin pointer. It also tracks downstream credits for every
// virtual channel on the output link.
//
// Ports
//   Clk, Reset      clock, synchronous active-high reset
//   i_req           per-input request (routed header targets this output)
//   i_prio          per-input priority, 1 = high
//   i_vc            per-input requested VC, input n at [n*VC_W +: VC_W]
//   i_beat          one flit moved on the output this cycle
//   i_last          that flit is the packet's last (qualified by i_beat)
//   i_cred_ret      one credit returned per VC bit
//   o_grant         registered one-hot grant, zero when idle
//   o_grant_vc      VC of the granted packet, zero when idle
//   o_flow_ok       granted VC has at least one credit
//   o_cred          credit count per VC, VC v at [v*CRED_W +: CRED_W]
//   o_cred_err      sticky credit overflow/underflow flag
// ---------------------------------------------------------------------------
module exa_crosb_vc_out_arbiter #(
    parameter int NUM_IN   = 4,
    parameter int NUM_VC   = 2,
    parameter int MAX_CRED = 8,
    parameter int VC_W     = 1,
    localparam int CRED_W  = $clog2(MAX_CRED + 1)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_IN-1:0]        i_req,
    input  logic [NUM_IN-1:0]        i_prio,
    input  logic [NUM_IN*VC_W-1:0]   i_vc,
    input  logic                     i_beat,
    input  logic                     i_last,
    input  logic [NUM_VC-1:0]        i_cred_ret,
    output logic [NUM_IN-1:0]        o_grant,
    output logic [VC_W-1:0]          o_grant_vc,
    output logic                     o_flow_ok,
    output logic [NUM_VC*CRED_W-1:0] o_cred,
    output logic                     o_cred_err
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [VC_W-1:0]   grant_vc_q, grant_vc_d;
    logic [PTR_W-1:0]  rr_hi_q, rr_hi_d;
    logic [PTR_W-1:0]  rr_lo_q, rr_lo_d;
    logic [CRED_W-1:0] cred_q [NUM_VC];
    logic [CRED_W-1:0] cred_d [NUM_VC];
    logic              cred_err_q, cred_err_d;

    logic [NUM_IN-1:0] elig;
    logic [NUM_IN-1:0] elig_hi;
    logic              use_hi;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [VC_W-1:0]   win_vc;
    logic [PTR_W-1:0]  next_ptr;

    // A request is only eligible if its VC exists and that VC has credit;
    // an out-of-range VC never matches any counter and so stays ineligible.
    always_comb begin
        logic [VC_W-1:0] vc_n;
        logic            has_cred;
        elig = '0;
        for (int n = 0; n < NUM_IN; n++) begin
            vc_n     = i_vc[n*VC_W +: VC_W];
            has_cred = 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                if (int'(vc_n) == v && cred_q[v] != '0) begin
                    has_cred = 1'b1;
                end
            end
            elig[n] = i_req[n] & has_cred;
        end
    end

    // High-priority requesters shadow low-priority ones entirely; each class
    // searches upward from its own pointer with wraparound.
    always_comb begin
        logic [NUM_IN-1:0] cand;
        logic [PTR_W-1:0]  idx_p;
        int                ptr;
        elig_hi   = elig & i_prio;
        use_hi    = |elig_hi;
        cand      = use_hi ? elig_hi : elig;
        ptr       = use_hi ? int'(rr_hi_q) : int'(rr_lo_q);
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx_p = PTR_W'((ptr + k) % NUM_IN);
            if (!win_found && cand[idx_p]) begin
                win_found = 1'b1;
                win_idx   = idx_p;
            end
        end
        win_vc   = i_vc[int'(win_idx)*VC_W +: VC_W];
        next_ptr = PTR_W'((int'(win_idx) + 1) % NUM_IN);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_vc_d = grant_vc_q;
        rr_hi_d    = rr_hi_q;
        rr_lo_d    = rr_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_LOCKED;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    grant_vc_d       = win_vc;
                    if (use_hi) begin
                        rr_hi_d = next_ptr;
                    end else begin
                        rr_lo_d = next_ptr;
                    end
                end
            end
            ST_LOCKED: begin
                if (i_beat && i_last) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    grant_vc_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_vc_d = '0;
            end
        endcase
    end

    // Return and consume on the same VC cancel out. Saturating at either end
    // keeps the counter meaningful and records the protocol violation.
    always_comb begin
        logic ret;
        logic con;
        cred_err_d = cred_err_q;
        for (int v = 0; v < NUM_VC; v++) begin
            ret       = i_cred_ret[v];
            con       = (state_q == ST_LOCKED) && i_beat && (int'(grant_vc_q) == v);
            cred_d[v] = cred_q[v];
            if (ret && !con) begin
                if (cred_q[v] == CRED_W'(MAX_CRED)) begin
                    cred_err_d = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + 1'b1;
                end
            end else if (con && !ret) begin
                if (cred_q[v] == '0) begin
                    cred_err_d = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_vc_q <= '0;
            rr_hi_q    <= '0;
            rr_lo_q    <= '0;
            cred_err_q <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                cred_q[v] <= CRED_W'(MAX_CRED);
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_vc_q <= grant_vc_d;
            rr_hi_q    <= rr_hi_d;
            rr_lo_q    <= rr_lo_d;
            cred_err_q <= cred_err_d;
            for (int v = 0; v < NUM_VC; v++) begin
                cred_q[v] <= cred_d[v];
            end
        end
    end

    always_comb begin
        o_flow_ok = 1'b0;
        o_cred    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            o_cred[v*CRED_W +: CRED_W] = cred_q[v];
            if (state_q == ST_LOCKED && int'(grant_vc_q) == v && cred_q[v] != '0) begin
                o_flow_ok = 1'b1;
            end
        end
    end

    assign o_grant    = grant_q;
    assign o_grant_vc = grant_vc_q;
    assign o_cred_err = cred_err_q;

endmodule

// File: tb/tb_exa_crosb_vc_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exa_crosb_vc_out_arbiter
//
// Scenario bench for the crossbar output arbiter at default parameters.
// Each scenario pushes the grants it expects into a queue when it drives the
// requests, and pops them when the arbiter raises a grant.
// ---------------------------------------------------------------------------
module tb_exa_crosb_vc_out_arbiter;

    localparam int NUM_IN   = 4;
    localparam int NUM_VC   = 2;
    localparam int MAX_CRED = 8;
    localparam int VC_W     = 1;
    localparam int CRED_W   = 4;

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic [NUM_IN-1:0]        i_req;
    logic [NUM_IN-1:0]        i_prio;
    logic [NUM_IN*VC_W-1:0]   i_vc;
    logic                     i_beat;
    logic                     i_last;
    logic [NUM_VC-1:0]        i_cred_ret;
    logic [NUM_IN-1:0]        o_grant;
    logic [VC_W-1:0]          o_grant_vc;
    logic                     o_flow_ok;
    logic [NUM_VC*CRED_W-1:0] o_cred;
    logic                     o_cred_err;

    typedef struct packed {
        logic [NUM_IN-1:0] grant;
        logic [VC_W-1:0]   vc;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    exa_crosb_vc_out_arbiter #(
        .NUM_IN  (NUM_IN),
        .NUM_VC  (NUM_VC),
        .MAX_CRED(MAX_CRED),
        .VC_W    (VC_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_req     (i_req),
        .i_prio    (i_prio),
        .i_vc      (i_vc),
        .i_beat    (i_beat),
        .i_last    (i_last),
        .i_cred_ret(i_cred_ret),
        .o_grant   (o_grant),
        .o_grant_vc(o_grant_vc),
        .o_flow_ok (o_flow_ok),
        .o_cred    (o_cred),
        .o_cred_err(o_cred_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [CRED_W-1:0] cred_of(input int v);
        return o_cred[v*CRED_W +: CRED_W];
    endfunction

    task automatic clear_inputs();
        i_req      = '0;
        i_prio     = '0;
        i_vc       = '0;
        i_beat     = 1'b0;
        i_last     = 1'b0;
        i_cred_ret = '0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Returns on the falling edge where a grant is first visible.
    task automatic wait_grant(input int max_cycles, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < max_cycles) begin
            @(negedge Clk);
            cycles++;
            if (o_grant !== '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        // Busy inputs during reset must have no effect on any state.
        Reset      = 1'b1;
        i_req      = 4'b1111;
        i_prio     = 4'b1010;
        i_vc       = 4'b0101;
        i_beat     = 1'b1;
        i_last     = 1'b1;
        i_cred_ret = 2'b11;
        repeat (3) @(negedge Clk);
        tests_run++;
        if (o_grant !== 4'b0000 || o_grant_vc !== 1'b0 || o_flow_ok !== 1'b0
            || o_cred !== {4'd8, 4'd8} || o_cred_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got grant=%b vc=%0d flow=%b cred=%h err=%b, expected 0000 0 0 88 0",
                     o_grant, o_grant_vc, o_flow_ok, o_cred, o_cred_err);
        end
        Reset = 1'b0;
        clear_inputs();
        @(negedge Clk);
        tests_run++;
        if (o_grant !== 4'b0000 || o_flow_ok !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got grant=%b flow=%b, expected 0000 0", o_grant, o_flow_ok);
        end
    endtask

    task automatic test_fairness();
        int   cyc;
        bit   ok;
        exp_t exp;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back({4'(1 << (i % NUM_IN)), 1'b0});
        i_req  = 4'b1111;
        i_prio = 4'b0000;
        i_vc   = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            wait_grant(8, cyc, ok);
            exp = exp_q.pop_front();
            tests_run++;
            if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc) begin
                tests_failed++;
                $display("[TB] FAIL fairness_grant%0d: got grant=%b vc=%0d latency=%0d, expected grant=%b vc=%0d latency=1",
                         i, o_grant, o_grant_vc, cyc, exp.grant, exp.vc);
            end
            i_beat = 1'b1;
            i_last = 1'b1;
            @(negedge Clk);
            i_beat = 1'b0;
            i_last = 1'b0;
            tests_run++;
            if (o_grant !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL fairness_gap%0d: got grant=%b, expected 0000", i, o_grant);
            end
        end
        tests_run++;
        if (cred_of(0) !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL fairness_cred0: got %0d, expected 3", cred_of(0));
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        int   cyc;
        bit   ok;
        exp_t exp;
        do_reset();
        exp_q.push_back({4'b0010, 1'b0});
        exp_q.push_back({4'b0001, 1'b0});
        i_req  = 4'b0011;
        i_prio = 4'b0010;
        i_vc   = 4'b0000;
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc) begin
            tests_failed++;
            $display("[TB] FAIL priority_high: got grant=%b vc=%0d latency=%0d, expected grant=%b vc=%0d latency=1",
                     o_grant, o_grant_vc, cyc, exp.grant, exp.vc);
        end
        i_beat = 1'b1;
        i_last = 1'b1;
        i_req  = 4'b0001;
        @(negedge Clk);
        i_beat = 1'b0;
        i_last = 1'b0;
        tests_run++;
        if (o_grant !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL priority_gap: got grant=%b, expected 0000", o_grant);
        end
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc) begin
            tests_failed++;
            $display("[TB] FAIL priority_low: got grant=%b vc=%0d latency=%0d, expected grant=%b vc=%0d latency=1",
                     o_grant, o_grant_vc, cyc, exp.grant, exp.vc);
        end
        i_beat = 1'b1;
        i_last = 1'b1;
        i_req  = 4'b0000;
        @(negedge Clk);
        clear_inputs();
    endtask

    task automatic test_lock_hold();
        int   cyc;
        bit   ok;
        exp_t exp;
        do_reset();
        exp_q.push_back({4'b0100, 1'b0});
        i_req = 4'b0100;
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc) begin
            tests_failed++;
            $display("[TB] FAIL lock_first: got grant=%b vc=%0d latency=%0d, expected grant=%b vc=%0d latency=1",
                     o_grant, o_grant_vc, cyc, exp.grant, exp.vc);
        end
        // Requests change completely under the lock.
        i_req  = 4'b0001;
        i_prio = 4'b0001;
        i_vc   = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            i_beat = 1'b1;
            @(negedge Clk);
            tests_run++;
            if (o_grant !== 4'b0100 || o_grant_vc !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL lock_hold%0d: got grant=%b vc=%0d, expected 0100 0", i, o_grant, o_grant_vc);
            end
        end
        i_last = 1'b1;
        @(negedge Clk);
        i_beat = 1'b0;
        i_last = 1'b0;
        tests_run++;
        if (o_grant !== 4'b0000 || o_grant_vc !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lock_release: got grant=%b vc=%0d, expected 0000 0", o_grant, o_grant_vc);
        end
        exp_q.push_back({4'b0001, 1'b1});
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc) begin
            tests_failed++;
            $display("[TB] FAIL lock_next: got grant=%b vc=%0d latency=%0d, expected grant=%b vc=%0d latency=1",
                     o_grant, o_grant_vc, cyc, exp.grant, exp.vc);
        end
        i_beat = 1'b1;
        i_last = 1'b1;
        i_req  = 4'b0000;
        @(negedge Clk);
        clear_inputs();
    endtask

    task automatic test_credits();
        int   cyc;
        bit   ok;
        exp_t exp;
        do_reset();
        exp_q.push_back({4'b0001, 1'b1});
        i_req = 4'b0001;
        i_vc  = 4'b0001;
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc || o_flow_ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL credit_grant: got grant=%b vc=%0d flow=%b, expected grant=%b vc=%0d flow=1",
                     o_grant, o_grant_vc, o_flow_ok, exp.grant, exp.vc);
        end
        for (int i = 0; i < 8; i++) begin
            i_beat = 1'b1;
            @(negedge Clk);
            tests_run++;
            if (cred_of(1) !== 4'(7 - i)) begin
                tests_failed++;
                $display("[TB] FAIL credit_beat%0d: got cred1=%0d, expected %0d", i, cred_of(1), 7 - i);
            end
        end
        i_beat = 1'b0;
        tests_run++;
        if (o_flow_ok !== 1'b0 || cred_of(0) !== 4'd8 || o_cred_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL credit_empty: got flow=%b cred0=%0d err=%b, expected 0 8 0",
                     o_flow_ok, cred_of(0), o_cred_err);
        end
        // A flit pushed with no credit left must saturate and flag an error.
        i_beat = 1'b1;
        @(negedge Clk);
        i_beat = 1'b0;
        tests_run++;
        if (cred_of(1) !== 4'd0 || o_cred_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL credit_underflow: got cred1=%0d err=%b, expected 0 1", cred_of(1), o_cred_err);
        end
        i_cred_ret = 2'b10;
        @(negedge Clk);
        i_cred_ret = 2'b00;
        tests_run++;
        if (o_flow_ok !== 1'b1 || cred_of(1) !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL credit_return: got flow=%b cred1=%0d, expected 1 1", o_flow_ok, cred_of(1));
        end
        i_beat     = 1'b1;
        i_cred_ret = 2'b10;
        @(negedge Clk);
        i_cred_ret = 2'b00;
        tests_run++;
        if (cred_of(1) !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL credit_cancel: got cred1=%0d, expected 1", cred_of(1));
        end
        i_last = 1'b1;
        i_req  = 4'b0000;
        @(negedge Clk);
        clear_inputs();
        tests_run++;
        if (cred_of(1) !== 4'd0 || o_grant !== 4'b0000 || cred_of(0) !== 4'd8 || o_cred_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL credit_end: got cred1=%0d grant=%b cred0=%0d err=%b, expected 0 0000 8 1",
                     cred_of(1), o_grant, cred_of(0), o_cred_err);
        end
    endtask

    task automatic test_elig_block();
        int   cyc;
        bit   ok;
        exp_t exp;
        do_reset();
        // Input 3 drains VC0; its grant also wraps the low pointer back to 0.
        exp_q.push_back({4'b1000, 1'b0});
        i_req = 4'b1000;
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc) begin
            tests_failed++;
            $display("[TB] FAIL elig_drain: got grant=%b vc=%0d, expected grant=%b vc=%0d",
                     o_grant, o_grant_vc, exp.grant, exp.vc);
        end
        for (int i = 0; i < 8; i++) begin
            i_beat = 1'b1;
            i_last = (i == 7);
            if (i == 7) i_req = 4'b0000;
            @(negedge Clk);
        end
        clear_inputs();
        tests_run++;
        if (cred_of(0) !== 4'd0 || o_grant !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL elig_drained: got cred0=%0d grant=%b, expected 0 0000", cred_of(0), o_grant);
        end
        exp_q.push_back({4'b0010, 1'b1});
        i_req = 4'b0011;
        i_vc  = 4'b0010;
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc != 1 || o_grant !== exp.grant || o_grant_vc !== exp.vc) begin
            tests_failed++;
            $display("[TB] FAIL elig_block: got grant=%b vc=%0d latency=%0d, expected grant=%b vc=%0d latency=1",
                     o_grant, o_grant_vc, cyc, exp.grant, exp.vc);
        end
        i_beat = 1'b1;
        i_last = 1'b1;
        i_req  = 4'b0000;
        @(negedge Clk);
        clear_inputs();
    endtask

    task automatic test_error_reset();
        int   cyc;
        bit   ok;
        exp_t exp;
        do_reset();
        i_cred_ret = 2'b01;
        @(negedge Clk);
        i_cred_ret = 2'b00;
        tests_run++;
        if (cred_of(0) !== 4'd8 || o_cred_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_overflow: got cred0=%0d err=%b, expected 8 1", cred_of(0), o_cred_err);
        end
        exp_q.push_back({4'b0001, 1'b0});
        i_req = 4'b0001;
        wait_grant(8, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || o_grant !== exp.grant || o_grant_vc !== exp.vc || o_cred_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_sticky_grant: got grant=%b vc=%0d err=%b, expected grant=%b vc=%0d err=1",
                     o_grant, o_grant_vc, o_cred_err, exp.grant, exp.vc);
        end
        i_beat = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (cred_of(0) !== 4'd7 || o_grant !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL err_midpacket: got cred0=%0d grant=%b, expected 7 0001", cred_of(0), o_grant);
        end
        Reset      = 1'b1;
        i_cred_ret = 2'b11;
        @(negedge Clk);
        tests_run++;
        if (o_grant !== 4'b0000 || o_cred !== {4'd8, 4'd8} || o_cred_err !== 1'b0 || o_flow_ok !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_reset_abort: got grant=%b cred=%h err=%b flow=%b, expected 0000 88 0 0",
                     o_grant, o_cred, o_cred_err, o_flow_ok);
        end
        Reset = 1'b0;
        clear_inputs();
        @(negedge Clk);
        tests_run++;
        if (o_grant !== 4'b0000 || o_flow_ok !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_no_residual: got grant=%b flow=%b, expected 0000 0", o_grant, o_flow_ok);
        end
    endtask

    initial begin
        Reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fairness();
        test_priority();
        test_lock_hold();
        test_credits();
        test_elig_block();
        test_error_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending grants, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
